// File: rtl/add_operand_sequencer.sv
// Serialises two MaxSize-bit operands, one WordSize word per transfer, into an external
// ripple-carry adder. It then waits Settle cycles and captures the adder's sum and carry.
module add_operand_sequencer #(
    parameter int unsigned MaxSize  = 128,
    parameter int unsigned WordSize = 32,
    parameter int unsigned Settle   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WordSize-1:0] in_data,
    input  logic                in_cin,
    output logic [MaxSize-1:0]  add_a,
    output logic [MaxSize-1:0]  add_b,
    output logic                add_cin,
    input  logic [MaxSize-1:0]  add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MaxSize-1:0]  out_sum,
    output logic                out_cout,
    output logic                busy
);

    localparam int unsigned NWORDS = MaxSize / WordSize;
    localparam int unsigned CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned SW     = (Settle > 1) ? $clog2(Settle) : 1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, HOLD} state_t;

    state_t                             state;
    logic [CW-1:0]                      word_cnt;
    logic [SW-1:0]                      settle_cnt;
    logic [NWORDS-1:0][WordSize-1:0]    a_words;
    logic [NWORDS-1:0][WordSize-1:0]    b_words;
    logic                               xfer;
    logic                               last_word;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign xfer      = in_valid && in_ready;
    assign last_word = (word_cnt == CW'(NWORDS - 1));
    assign add_a     = a_words;
    assign add_b     = b_words;

    // Operands stay frozen from the last B word until the result is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            word_cnt   <= '0;
            settle_cnt <= '0;
            a_words    <= '0;
            b_words    <= '0;
            add_cin    <= 1'b0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        a_words[word_cnt] <= in_data;
                        if (word_cnt == '0) begin
                            add_cin <= in_cin;
                        end
                        busy <= 1'b1;
                        if (last_word) begin
                            word_cnt <= '0;
                            state    <= LOAD_B;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_words[word_cnt] <= in_data;
                        if (last_word) begin
                            word_cnt   <= '0;
                            settle_cnt <= SW'(Settle - 1);
                            state      <= SETTLE;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        out_sum   <= add_sum;
                        out_cout  <= add_cout;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        word_cnt  <= '0;
                        state     <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Directed bench: default build plus a Settle=1 build, adder modelled as a + b + cin.
module tb_add_operand_sequencer;

    logic         clk;
    logic         rst;

    logic         in_valid, in_ready, in_cin, add_cin, add_cout;
    logic         out_valid, out_ready, out_cout, busy;
    logic [31:0]  in_data;
    logic [127:0] add_a, add_b, add_sum, out_sum;

    logic         s_in_valid, s_in_ready, s_in_cin, s_add_cin, s_add_cout;
    logic         s_out_valid, s_out_ready, s_out_cout, s_busy;
    logic [31:0]  s_in_data;
    logic [127:0] s_add_a, s_add_b, s_add_sum, s_out_sum;

    int checks = 0;
    int passes = 0;

    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + 129'(add_cin);
    assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + 129'(s_add_cin);

    add_operand_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    add_operand_sequencer #(.Settle(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_cin(s_in_cin),
        .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
        .add_sum(s_add_sum), .add_cout(s_add_cout),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input bit u, input logic [31:0] d, input logic c);
        int n = 0;
        if (u) begin
            s_in_valid = 1'b1; s_in_data = d; s_in_cin = c;
        end else begin
            in_valid = 1'b1; in_data = d; in_cin = c;
        end
        while (!(u ? s_in_ready : in_ready) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_word: in_ready never rose within %0d cycles", n);
        end
        tick();
        if (u) s_in_valid = 1'b0;
        else   in_valid   = 1'b0;
    endtask

    task automatic load_op(input bit u, input logic [127:0] a, input logic [127:0] b,
                           input logic c, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                logic [127:0] a0, b0;
                a0 = add_a; b0 = add_b;
                tick();
                checks++;
                if ({add_a, add_b} !== {a0, b0})
                    $display("FAIL stall_hold: operands changed during idle cycle a=%h b=%h", add_a, add_b);
                else
                    passes++;
            end
            if (k < 4) send_word(u, a[k*32 +: 32], (k == 0) ? c : 1'b0);
            else       send_word(u, b[(k-4)*32 +: 32], 1'b0);
        end
    endtask

    task automatic wait_result(input bit u, input int exp_lat, input string name);
        int n = 0;
        while (!(u ? s_out_valid : out_valid) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== exp_lat)
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, exp_lat);
        else
            passes++;
    endtask

    task automatic check_sum(input logic [127:0] s, input logic co, input string name);
        checks++;
        if ({out_cout, out_sum} !== {co, s})
            $display("FAIL %s_sum: got cout=%b sum=%h expected cout=%b sum=%h", name, out_cout, out_sum, co, s);
        else
            passes++;
    endtask

    task automatic accept(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL %s_accept: got valid/ready/busy=%b%b%b expected 010", name, out_valid, in_ready, busy);
        else
            passes++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({add_a, add_b, add_cin, out_sum, out_cout, out_valid, busy} !== '0)
            $display("FAIL reset_outputs: got a=%h b=%h cin=%b sum=%h cout=%b valid=%b busy=%b",
                     add_a, add_b, add_cin, out_sum, out_cout, out_valid, busy);
        else
            passes++;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else
            passes++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_carry();
        load_op(0, {4{32'hFFFF_FFFF}}, 128'h0, 1'b1, 0);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100)
            $display("FAIL carry_settle_flags: got busy/ready/valid=%b%b%b expected 100", busy, in_ready, out_valid);
        else
            passes++;
        wait_result(0, 4, "carry");
        check_sum(128'h0, 1'b1, "carry");
        accept("carry");
    endtask

    task automatic test_pattern();
        load_op(0, 128'h0000_0001_0000_0002_0000_0003_0000_0004,
                   128'h0000_0001_0000_0002_0000_0003_0000_0004, 1'b0, 0);
        wait_result(0, 4, "pattern");
        check_sum(128'h0000_0002_0000_0004_0000_0006_0000_0008, 1'b0, "pattern");
        accept("pattern");
    endtask

    task automatic test_gaps();
        load_op(0, 128'hDEAD_BEEF_0000_0000_FFFF_FFFF_1234_5678,
                   128'h0000_0001_0000_0000_0000_0001_1111_1111, 1'b1, 1);
        wait_result(0, 4, "gaps");
        check_sum(128'hDEAD_BEF0_0000_0001_0000_0000_2345_678A, 1'b0, "gaps");
        accept("gaps");
    endtask

    task automatic test_back_pressure();
        logic [127:0] exp_s;
        exp_s = 128'h0000_0000_0000_0000_0000_0000_0000_0008;
        load_op(0, 128'h5, 128'h3, 1'b0, 0);
        wait_result(0, 4, "hold");
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, exp_s})
                $display("FAIL hold_stable_%0d: got valid=%b ready=%b sum=%h expected valid=1 ready=0 sum=%h",
                         i, out_valid, in_ready, out_sum, exp_s);
            else
                passes++;
        end
        accept("hold");
        check_sum(exp_s, 1'b0, "hold_retained");
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        for (int k = 0; k < 4; k++) send_word(0, (k == 0) ? 32'h1 : 32'h0, 1'b0);
        send_word(0, 32'h7, 1'b0);
        send_word(0, 32'h9, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({add_a, add_b, add_cin, out_sum, out_cout, out_valid, busy} !== '0)
            $display("FAIL abort_zero: got a=%h b=%h sum=%h valid=%b busy=%b", add_a, add_b, out_sum, out_valid, busy);
        else
            passes++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen || busy !== 1'b0)
            $display("FAIL abort_discard: got valid_seen=%b busy=%b expected 0 0", seen, busy);
        else
            passes++;
        load_op(0, 128'h1, 128'h1, 1'b0, 0);
        wait_result(0, 4, "abort_next");
        check_sum(128'h2, 1'b0, "abort_next");
        accept("abort_next");
    endtask

    task automatic test_settle_one();
        load_op(1, {32'h8000_0000, 96'h0}, {32'h8000_0000, 96'h0}, 1'b0, 0);
        wait_result(1, 1, "settle1");
        checks++;
        if ({s_out_cout, s_out_sum} !== {1'b1, 128'h0})
            $display("FAIL settle1_sum: got cout=%b sum=%h expected cout=1 sum=0", s_out_cout, s_out_sum);
        else
            passes++;
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        checks++;
        if ({s_out_valid, s_in_ready} !== 2'b01)
            $display("FAIL settle1_accept: got valid/ready=%b%b expected 01", s_out_valid, s_in_ready);
        else
            passes++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_cin = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_carry();
        test_pattern();
        test_gaps();
        test_back_pressure();
        test_reset_abort();
        test_settle_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
